pwm_audio_decoder: RTL and testbench
====================================

Name: pwm_audio_decoder

Overview:
- Receiver for the 1-bit PWM audio stream produced by the synth/graphics top.
- Recovers one unsigned sample per PWM period by counting high bits and undoing the per-period polarity inversion.
- Checks each period's shape and length, and emits a sample plus valid strobe.
- Used on-chip for the audio loopback/visualiser path and by the bench as a scoreboard front end.

Parameters:
- PERIOD, 100: enabled clock cycles per PWM period (the program-address sweep length).
- SAMPLE_BITS, 7: width of the recovered sample; must satisfy 2**SAMPLE_BITS > PERIOD.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  qualifies the PWM bit this cycle; cycles with enable=0 are ignored entirely.
- period_start  in  1  marks the first enabled bit of a period (counter==0); meaningful only when enable=1.
- invert  in  1  polarity of the period starting this cycle (1 = stream is complemented); sampled only with period_start & enable.
- pwm_in  in  1  PWM audio bit.
- sample  out  SAMPLE_BITS  last recovered sample, held between strobes.
- sample_valid  out  1  one-cycle strobe; sample updated the same cycle.
- shape_err  out  1  sticky; the last completed period had more than one edge.
- length_err  out  1  sticky; the last completed period length was not PERIOD.
- locked  out  1  at least one period_start seen since reset.

Behaviour:
- Reset (rst_n=0, async): all counters and state 0. Outputs: sample=0, sample_valid=0, shape_err=0, length_err=0, locked=0.
- States: HUNT then RUN.
  - HUNT: ignore bits until enable & period_start. On that cycle, go to RUN and start a new period with this bit. No strobe on that cycle (the preceding partial period is discarded).
  - RUN: stays in RUN until reset.
- Per-period registers:
  - len: count of enabled bits, saturating at 2**SAMPLE_BITS-1.
  - ones: count of enabled bits with (pwm_in ^ pol)=1, where pol is invert latched at period_start.
  - edges: count of changes in the decoded bit between consecutive enabled bits within the period, saturating at 3.
  - prev: the previous decoded bit.
- Expected period shape: the decoded bit is 1 for the first `sample` bits, then 0, so edges ≤ 1. A run of 1s not starting at bit 0 counts as a shape error, and a leading 0 followed by 1 also counts as an edge violation.
  - Rule: shape fault if edges>1, OR (edges==1 AND the first decoded bit was 0).
- Period close, on enable & period_start while in RUN:
  - The completed period's result is evaluated combinationally from its registers.
  - len==PERIOD and no shape fault → next cycle: sample=ones, sample_valid=1, both error flags cleared.
  - len!=PERIOD → length_err=1, sample held, no strobe.
  - Shape fault (with correct length) → shape_err=1, sample held, no strobe.
  - The closing cycle's bit is the first bit of the new period:
    - len=1, ones=(pwm_in^invert), edges=0, pol=invert.
- Latency: the strobe comes exactly 1 clk after the period_start cycle that closes the period.
- Overlength: if len reaches PERIOD+1 with no period_start, the period is marked bad; length_err is set at the next close. len saturates and does not wrap.
- enable=0 cycles: no register changes except the strobe self-clearing. period_start is ignored when enable=0.
- Arithmetic: all counters are unsigned SAMPLE_BITS wide. ones ≤ len is guaranteed by construction. Boundary samples 0 (all decoded 0) and PERIOD (all decoded 1) are legal, with edges=0.
- Mid-operation reset: immediate return to HUNT; any pending strobe is suppressed.

Decomposition:
- Shared package holds:
  - decoder state enum {HUNT, RUN};
  - constant for the default period (tied to the program-address sweep);
  - a function computing the encoder-side bit (sample > counter) ^ invert, reused by the bench model.
- One natural sub-module, pwm_period_counter: len/ones/edges/prev/pol registers with a clear-and-load on period_start. The top keeps the FSM, the close logic and the output registers.

Test Plan:
- Reset then one partial period, then full periods encoding 37 (invert=0) and 37 (invert=1) → no strobe for the partial period; then two strobes of sample=37, each 1 clk after its closing period_start; errors stay 0.
- Boundary samples 0, PERIOD, 1, PERIOD-1 with alternating invert → strobes 0, 100, 1, 99.
- enable toggled 1-of-2 cycles across periods encoding 50 → sample=50; idle cycles change nothing.
- Period of 99 enabled bits encoding 20 → no strobe; length_err=1 and sample holds its previous value. A following good period encoding 20 → strobe 20 and length_err clears.
- Decoded pattern 1110011000… over 100 bits → shape_err=1 and no strobe. A pattern starting 0 then 1s → shape_err=1.
- rst_n asserted mid-period, released, then periods encoding 64 → locked=0 until the first period_start; the first strobe is 64, one period after lock.

Source files
------------

// File: rtl/pwm_audio_decoder_pkg.sv
// Shared types, constants and the encoder-side bit function for the PWM audio decoder.
package pwm_audio_decoder_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One PWM period spans the full program-address sweep of the synth top.
    localparam int DEFAULT_PERIOD = 100;

    // Bit the encoder emits at position `counter` of a period carrying `sample`.
    function automatic logic encode_bit(input int unsigned sample,
                                        input int unsigned counter,
                                        input logic invert);
        return (sample > counter) ^ invert;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Per-period statistics: enabled-bit length, decoded ones, edge count, first/previous bit and polarity.
module pwm_period_counter
    import pwm_audio_decoder_pkg::*;
#(
    parameter int SAMPLE_BITS = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic                   i_load,
    input  logic                   i_invert,
    input  logic                   i_pwm,
    output logic [SAMPLE_BITS-1:0] o_len,
    output logic [SAMPLE_BITS-1:0] o_ones,
    output logic [1:0]             o_edges,
    output logic                   o_first
);

    localparam logic [SAMPLE_BITS-1:0] CNT_MAX = '1;

    logic [SAMPLE_BITS-1:0] r_len;
    logic [SAMPLE_BITS-1:0] r_ones;
    logic [1:0]             r_edges;
    logic                   r_prev;
    logic                   r_first;
    logic                   r_pol;
    logic                   w_dec;

    // The loading bit already uses the new period's polarity.
    assign w_dec = i_pwm ^ (i_load ? i_invert : r_pol);

    // NOTE: every register here is plain state (no memory array), so all of it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_ones  <= '0;
            r_edges <= '0;
            r_prev  <= 1'b0;
            r_first <= 1'b0;
            r_pol   <= 1'b0;
        end else if (i_enable) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            if (i_load) begin
                r_len   <= SAMPLE_BITS'(1);
                r_ones  <= SAMPLE_BITS'(w_dec);
                r_edges <= 2'd0;
                r_prev  <= w_dec;
                r_first <= w_dec;
                r_pol   <= i_invert;
            end else begin
                if (r_len != CNT_MAX)
                    r_len <= r_len + 1'b1;
                if (w_dec && r_ones != CNT_MAX)
                    r_ones <= r_ones + 1'b1;
                if (w_dec != r_prev && r_edges != 2'd3)
                    r_edges <= r_edges + 2'd1;
                r_prev <= w_dec;
            end
        end
    end

    assign o_len   = r_len;
    assign o_ones  = r_ones;
    assign o_edges = r_edges;
    assign o_first = r_first;

endmodule

// File: rtl/pwm_audio_decoder.sv
// Recovers one unsigned audio sample per PWM period and flags malformed periods.
module pwm_audio_decoder
    import pwm_audio_decoder_pkg::*;
#(
    parameter int PERIOD      = DEFAULT_PERIOD,
    parameter int SAMPLE_BITS = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   period_start,
    input  logic                   invert,
    input  logic                   pwm_in,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   sample_valid,
    output logic                   shape_err,
    output logic                   length_err,
    output logic                   locked
);

    localparam logic [SAMPLE_BITS-1:0] LEN_OK = SAMPLE_BITS'(PERIOD);

    state_t                 r_state;
    logic [SAMPLE_BITS-1:0] r_sample;
    logic                   r_valid;
    logic                   r_shape_err;
    logic                   r_length_err;
    logic                   r_locked;

    logic                   w_close;
    logic [SAMPLE_BITS-1:0] w_len;
    logic [SAMPLE_BITS-1:0] w_ones;
    logic [1:0]             w_edges;
    logic                   w_first;
    logic                   w_len_ok;
    logic                   w_shape_fault;

    assign w_close = enable & period_start;

    pwm_period_counter #(
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (enable),
        .i_load   (w_close),
        .i_invert (invert),
        .i_pwm    (pwm_in),
        .o_len    (w_len),
        .o_ones   (w_ones),
        .o_edges  (w_edges),
        .o_first  (w_first)
    );

    // Saturated lengths never wrap back to PERIOD, so overlength lands here too.
    assign w_len_ok      = (w_len == LEN_OK);
    assign w_shape_fault = (w_edges > 2'd1) || (w_edges == 2'd1 && !w_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_shape_err  <= 1'b0;
            r_length_err <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_close) begin
                case (r_state)
                    HUNT: begin
                        r_state  <= RUN;
                        r_locked <= 1'b1;
                    end
                    RUN: begin
                        if (!w_len_ok) begin
                            r_length_err <= 1'b1;
                        end else if (w_shape_fault) begin
                            r_shape_err <= 1'b1;
                        end else begin
                            r_sample     <= w_ones;
                            r_valid      <= 1'b1;
                            r_shape_err  <= 1'b0;
                            r_length_err <= 1'b0;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign shape_err    = r_shape_err;
    assign length_err   = r_length_err;
    assign locked       = r_locked;

endmodule

// File: tb/tb_pwm_audio_decoder.sv
// Directed bench: a queue-based period model checked every cycle, plus literal checks at each period close.
module tb_pwm_audio_decoder;
    import pwm_audio_decoder_pkg::*;

    localparam int PERIOD = 100;
    localparam int SB     = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          period_start = 1'b0;
    logic          invert = 1'b0;
    logic          pwm_in = 1'b0;
    logic [SB-1:0] sample;
    logic          sample_valid;
    logic          shape_err;
    logic          length_err;
    logic          locked;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    pwm_audio_decoder #(
        .PERIOD      (PERIOD),
        .SAMPLE_BITS (SB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .period_start (period_start),
        .invert       (invert),
        .pwm_in       (pwm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .shape_err    (shape_err),
        .length_err   (length_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decoded bits of the open period are kept in a queue and judged as a whole at close.
    bit m_hunting = 1'b1;
    bit m_locked  = 1'b0;
    bit m_valid   = 1'b0;
    bit m_serr    = 1'b0;
    bit m_lerr    = 1'b0;
    int m_sample  = 0;
    bit m_pol     = 1'b0;
    bit m_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hunting = 1'b1;
            m_locked  = 1'b0;
            m_valid   = 1'b0;
            m_serr    = 1'b0;
            m_lerr    = 1'b0;
            m_sample  = 0;
            m_pol     = 1'b0;
            m_q.delete();
        end else begin
            m_valid = 1'b0;
            if (enable) begin
                if (period_start) begin
                    if (m_hunting) begin
                        m_hunting = 1'b0;
                        m_locked  = 1'b1;
                    end else begin
                        int  ones;
                        bit  seen0;
                        bit  shape_ok;
                        ones = 0; seen0 = 1'b0; shape_ok = 1'b1;
                        // A well-formed period is a run of ones followed only by zeros.
                        foreach (m_q[i]) begin
                            if (m_q[i]) begin
                                ones++;
                                if (seen0) shape_ok = 1'b0;
                            end else begin
                                seen0 = 1'b1;
                            end
                        end
                        if (m_q.size() != PERIOD) m_lerr = 1'b1;
                        else if (!shape_ok)       m_serr = 1'b1;
                        else begin
                            m_sample = ones;
                            m_valid  = 1'b1;
                            m_serr   = 1'b0;
                            m_lerr   = 1'b0;
                        end
                    end
                    m_pol = invert;
                    m_q.delete();
                    m_q.push_back(pwm_in ^ invert);
                end else if (!m_hunting) begin
                    m_q.push_back(pwm_in ^ m_pol);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_sample", int'(sample), m_sample);
            check("cmp_valid", int'(sample_valid), int'(m_valid));
            check("cmp_shape_err", int'(shape_err), int'(m_serr));
            check("cmp_length_err", int'(length_err), int'(m_lerr));
            check("cmp_locked", int'(locked), int'(m_locked));
        end
    end

    task automatic drive(input logic en, input logic ps, input logic inv, input logic b);
        enable       = en;
        period_start = ps;
        invert       = inv;
        pwm_in       = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input int mode, input int c);
        if (mode == 1) return (c < 3) || (c == 5) || (c == 6);   // 1110011000...
        return (c >= 1) && (c <= 10);                            // 0111111111100...
    endfunction

    // Plays one period; checks the result of the period closed by its first bit.
    task automatic run_period(input int mode, input int s, input logic inv, input int n,
                              input bit half, input bit exp_strobe, input int exp_val,
                              input bit exp_lerr, input bit exp_serr);
        logic b;
        for (int c = 0; c < n; c++) begin
            if (mode == 0) b = encode_bit(s, c, inv);
            else           b = pat_bit(mode, c) ^ inv;
            if (half)
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            drive(1'b1, c == 0, inv, b);
            if (c == 0) begin
                check("close_strobe", int'(sample_valid), int'(exp_strobe));
                check("close_sample", int'(sample), exp_val);
                check("close_length_err", int'(length_err), int'(exp_lerr));
                check("close_shape_err", int'(shape_err), int'(exp_serr));
                check("close_locked", int'(locked), 1);
                check("model_sample", m_sample, exp_val);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_errs", int'({shape_err, length_err}), 0);
        check("rst_locked", int'(locked), 0);
        rst_n = 1'b1;

        // Partial period while hunting, then two periods of 37 with both polarities.
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 1'b0, 1'(i < 12));
        check("hunt_locked", int'(locked), 0);
        run_period(0, 37, 1'b0, PERIOD, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_period(0, 37, 1'b1, PERIOD, 1'b0, 1'b1, 37, 1'b0, 1'b0);

        // Boundary samples with alternating invert.
        run_period(0, 0, 1'b0, PERIOD, 1'b0, 1'b1, 37, 1'b0, 1'b0);
        run_period(0, PERIOD, 1'b1, PERIOD, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_period(0, 1, 1'b0, PERIOD, 1'b0, 1'b1, 100, 1'b0, 1'b0);
        run_period(0, PERIOD - 1, 1'b1, PERIOD, 1'b0, 1'b1, 1, 1'b0, 1'b0);

        // Enable active one cycle in two.
        run_period(0, 50, 1'b0, PERIOD, 1'b1, 1'b1, 99, 1'b0, 1'b0);

        // Short period, then a good one.
        run_period(0, 20, 1'b0, PERIOD - 1, 1'b0, 1'b1, 50, 1'b0, 1'b0);
        run_period(0, 20, 1'b1, PERIOD, 1'b0, 1'b0, 50, 1'b1, 1'b0);

        // Shape faults.
        run_period(1, 0, 1'b0, PERIOD, 1'b0, 1'b1, 20, 1'b0, 1'b0);
        run_period(2, 0, 1'b1, PERIOD, 1'b0, 1'b0, 20, 1'b0, 1'b1);
        run_period(0, 64, 1'b0, 40, 1'b0, 1'b0, 20, 1'b0, 1'b1);

        // Mid-period reset, then periods of 64.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_rst_sample", int'(sample), 0);
        check("mid_rst_errs", int'({shape_err, length_err}), 0);
        check("mid_rst_locked", int'(locked), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("relock_locked", int'(locked), 0);
        run_period(0, 64, 1'b0, PERIOD, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_period(0, 64, 1'b1, PERIOD, 1'b0, 1'b1, 64, 1'b0, 1'b0);
        run_period(0, 0, 1'b0, 1, 1'b0, 1'b1, 64, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("strobe_clears", int'(sample_valid), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
